game_sequencer: RTL and testbench
=================================

// Module: game_sequencer
// PURPOSE
// Top-level game controller for the doodle jump datapath. It generates the frame tick and sequences the game states idle/start/play/over.
// It holds the doodle block in reset outside play, and computes the per-frame world scroll step when the doodle rises above the scroll line.
// It also accumulates the score. Sits between the button inputs and the doodle, platform and renderer blocks.
// PARAMETERS
// CLK              50000000  system clock frequency, Hz
// FPS              50        frame ticks per second; tick period P = CLK/FPS cycles
// SCREEN_H         768       doodle_y >= SCREEN_H means doodle fell off screen
// SCROLL_LINE      300       doodle_y below this value triggers scrolling
// MAX_SCROLL_STEP  16        per-frame scroll clamp, pixels (<= 31)
// PORTS
// clk          in   1   system clock
// rst          in   1   synchronous, active-high reset
// start_btn    in   1   start button, already synchronised, level
// pause_btn    in   1   pause button, level; used only with GAME_PAUSE_EN
// doodle_y     in   10  doodle top-edge row, unsigned
// frame_tick   out  1   one-cycle pulse every P cycles
// doodle_rst   out  1   reset for doodle/platform blocks
// scroll_valid out  1   one-cycle pulse: scroll_step is valid
// scroll_step  out  5   pixels the world moves down this frame
// score        out  16  accumulated scroll distance, saturating
// game_state   out  2   0 IDLE, 1 START, 2 PLAY, 3 OVER (PAUSE encodes as 2 + paused)
// paused       out  1   1 while in PAUSE; constant 0 without GAME_PAUSE_EN
// BEHAVIOUR
// - Reset values: frame_tick=0, scroll_valid=0, scroll_step=0, score=0, game_state=IDLE, doodle_rst=1, paused=0, tick counter=0, btn edge regs=0.
// - Tick counter: counts 0..P-1 and then wraps to 0. frame_tick=1 in the cycle after the counter equals P-1. The counter runs in every state and is cleared only by rst.
// - start_btn and pause_btn are edge-detected: rise = btn & ~btn_q. A level held high produces a single rise only.
// - IDLE:  doodle_rst=1. start rise -> START.
// - START: doodle_rst=1; score cleared to 0 on entry. At the next frame_tick -> PLAY. START therefore lasts at least one cycle and at most P cycles.
// - PLAY:  doodle_rst=0.
//   - On frame_tick with doodle_y >= SCREEN_H -> OVER. No scroll this frame.
//   - On frame_tick with doodle_y < SCROLL_LINE: step = min(SCROLL_LINE - doodle_y, MAX_SCROLL_STEP). The subtraction is done in 10 bits and the result is clamped before truncation to 5 bits.
//   - scroll_step is registered. scroll_valid pulses exactly 1 cycle after frame_tick, which is 2-cycle latency from the counter wrap.
//   - score += step in the same cycle as scroll_valid. score saturates at 16'hFFFF with no wrap.
//   - Otherwise scroll_step=0 and scroll_valid stays 0.
// - OVER:  doodle_rst=1. score is held. start rise -> START.
// - Simultaneous events: a fall check and a scroll check on the same tick resolve as fall. The two are exclusive anyway, since SCROLL_LINE < SCREEN_H.
// - A start rise in PLAY is ignored.
// - rst asserted mid-play: in the next cycle every register is at its reset value and no pending scroll_valid is emitted.
// - scroll_step keeps its last value between pulses. Consumers must qualify it with scroll_valid.
// CONFIGURATION
// GAME_PAUSE_EN defined:
// - A pause rise in PLAY -> PAUSE: paused=1, doodle_rst=0, and no scroll or fall checks are made.
// - Downstream gates motion on paused. A pause rise in PAUSE -> PLAY. The tick counter keeps running.
// - A start rise in PAUSE -> START, which abandons the game.
// GAME_PAUSE_EN undefined:
// - pause_btn is ignored, paused is tied to 0, and the PAUSE state does not exist.
// TESTING (CLK=1000, FPS=10 -> P=100)
// - Apply rst for 2 cycles, then run 250 cycles -> frame_tick high at exactly cycles 100 and 200 after the rst release. Outputs stay at their reset values.
// - start_btn held high for 500 cycles from IDLE -> one START and then PLAY at the next tick, with doodle_rst falling there. No second START occurs.
// - In PLAY with doodle_y=290 at a tick -> scroll_valid 1 cycle later, scroll_step=10, score=10. With doodle_y=100 -> step=16, score=26. With doodle_y=400 -> no pulse.
// - Preload score=16'hFFF8 and scroll with doodle_y=100 -> score=16'hFFFF, and it stays there on the next scroll.
// - doodle_y=768 at a tick -> OVER on the next cycle with doodle_rst=1 and score held. A start rise -> START, then score=0.
// - Assert rst on the tick cycle of a scrolling frame -> no scroll_valid, and state=IDLE.
// - With GAME_PAUSE_EN: pause rise -> paused=1, and no scroll with doodle_y=100 for 3 ticks. A second rise -> PLAY, and scrolling resumes.

Source files
------------

// File: rtl/game_sequencer_if.sv
// Button/doodle inputs and frame/scroll/score outputs of the game sequencer.
// The slave modport is the sequencer's view; master is the driver/observer side.
interface game_sequencer_if;
  logic        start_btn;
  logic        pause_btn;
  logic [9:0]  doodle_y;
  logic        frame_tick;
  logic        doodle_rst;
  logic        scroll_valid;
  logic [4:0]  scroll_step;
  logic [15:0] score;
  logic [1:0]  game_state;
  logic        paused;

  modport slave (
    input  start_btn, pause_btn, doodle_y,
    output frame_tick, doodle_rst, scroll_valid, scroll_step, score, game_state, paused
  );

  modport master (
    output start_btn, pause_btn, doodle_y,
    input  frame_tick, doodle_rst, scroll_valid, scroll_step, score, game_state, paused
  );
endinterface

// File: rtl/game_sequencer.sv
// Doodle-jump game controller: frame tick, IDLE/START/PLAY/OVER sequencing, scroll step and score.
// Optional pause state is built when GAME_PAUSE_EN is defined.
module game_sequencer #(
  parameter int unsigned CLK             = 50000000,
  parameter int unsigned FPS             = 50,
  parameter int unsigned SCREEN_H        = 768,
  parameter int unsigned SCROLL_LINE     = 300,
  parameter int unsigned MAX_SCROLL_STEP = 16
) (
  input logic             clk_i,
  input logic             rst_i,
  game_sequencer_if.slave bus
);

  localparam int unsigned      PERIOD        = CLK / FPS;
  localparam int unsigned      CNT_W         = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
  localparam logic [9:0]       SCREEN_H_V    = 10'(SCREEN_H);
  localparam logic [9:0]       SCROLL_LINE_V = 10'(SCROLL_LINE);
  localparam logic [9:0]       MAX_STEP_V    = 10'(MAX_SCROLL_STEP);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_PLAY  = 3'd2,
    S_OVER  = 3'd3
`ifdef GAME_PAUSE_EN
    ,S_PAUSE = 3'd4
`endif
  } state_e;

`ifdef GAME_PAUSE_EN
  localparam state_e PAUSE_TARGET = S_PAUSE;
`else
  localparam state_e PAUSE_TARGET = S_PLAY;
`endif

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             frame_tick_q, frame_tick_d;
  logic             start_btn_q;
  state_e           state_q, state_d;
  logic             doodle_rst_q, doodle_rst_d;
  logic             scroll_valid_q, scroll_valid_d;
  logic [4:0]       scroll_step_q, scroll_step_d;
  logic [15:0]      score_q, score_d;
  logic [1:0]       game_state_q, game_state_d;
  logic             paused_q, paused_d;

  logic             start_rise_s;
  logic             pause_rise_s;
  logic [9:0]       diff_s;
  logic [4:0]       step_s;
  logic [16:0]      sum_s;
  logic [15:0]      sat_s;

  assign start_rise_s = bus.start_btn & ~start_btn_q;

`ifdef GAME_PAUSE_EN
  logic pause_btn_q;
  assign pause_rise_s = bus.pause_btn & ~pause_btn_q;

  // Pause button edge register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pause_btn_q <= 1'b0;
    end else begin
      pause_btn_q <= bus.pause_btn;
    end
  end
`else
  logic pause_unused;
  assign pause_unused = bus.pause_btn;
  assign pause_rise_s = 1'b0;
`endif

  // Clamp before truncating so a large distance never wraps into a small step.
  assign diff_s = SCROLL_LINE_V - bus.doodle_y;
  assign step_s = (diff_s > MAX_STEP_V) ? MAX_STEP_V[4:0] : diff_s[4:0];
  assign sum_s  = {1'b0, score_q} + {12'd0, step_s};
  assign sat_s  = sum_s[16] ? 16'hFFFF : sum_s[15:0];

  // Free-running frame counter, wraps at PERIOD-1
  always_comb begin
    frame_tick_d = (cnt_q == CNT_LAST);
    if (cnt_q == CNT_LAST) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Next-state, scroll and score logic
  always_comb begin
    state_d        = state_q;
    scroll_valid_d = 1'b0;
    scroll_step_d  = scroll_step_q;
    score_d        = score_q;
    case (state_q)
      S_IDLE, S_OVER: begin
        if (start_rise_s) begin
          state_d = S_START;
          score_d = 16'd0;
        end else begin
          state_d = state_q;
        end
      end
      S_START: begin
        if (frame_tick_q) begin
          state_d = S_PLAY;
        end else begin
          state_d = S_START;
        end
      end
      S_PLAY: begin
        if (pause_rise_s) begin
          state_d = PAUSE_TARGET;
        end else if (frame_tick_q) begin
          if (bus.doodle_y >= SCREEN_H_V) begin
            state_d       = S_OVER;
            scroll_step_d = 5'd0;
          end else if (bus.doodle_y < SCROLL_LINE_V) begin
            scroll_valid_d = 1'b1;
            scroll_step_d  = step_s;
            score_d        = sat_s;
          end else begin
            scroll_step_d = 5'd0;
          end
        end else begin
          state_d = S_PLAY;
        end
      end
`ifdef GAME_PAUSE_EN
      S_PAUSE: begin
        if (start_rise_s) begin
          state_d = S_START;
          score_d = 16'd0;
        end else if (pause_rise_s) begin
          state_d = S_PLAY;
        end else begin
          state_d = S_PAUSE;
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered outputs follow the upcoming state; PAUSE reports as PLAY with paused set
  always_comb begin
    doodle_rst_d = 1'b1;
    paused_d     = 1'b0;
    game_state_d = 2'd0;
    case (state_d)
      S_IDLE:  game_state_d = 2'd0;
      S_START: game_state_d = 2'd1;
      S_PLAY: begin
        game_state_d = 2'd2;
        doodle_rst_d = 1'b0;
      end
      S_OVER:  game_state_d = 2'd3;
`ifdef GAME_PAUSE_EN
      S_PAUSE: begin
        game_state_d = 2'd2;
        doodle_rst_d = 1'b0;
        paused_d     = 1'b1;
      end
`endif
      default: game_state_d = 2'd0;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q          <= {CNT_W{1'b0}};
      frame_tick_q   <= 1'b0;
      start_btn_q    <= 1'b0;
      state_q        <= S_IDLE;
      doodle_rst_q   <= 1'b1;
      scroll_valid_q <= 1'b0;
      scroll_step_q  <= 5'd0;
      score_q        <= 16'd0;
      game_state_q   <= 2'd0;
      paused_q       <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      frame_tick_q   <= frame_tick_d;
      start_btn_q    <= bus.start_btn;
      state_q        <= state_d;
      doodle_rst_q   <= doodle_rst_d;
      scroll_valid_q <= scroll_valid_d;
      scroll_step_q  <= scroll_step_d;
      score_q        <= score_d;
      game_state_q   <= game_state_d;
      paused_q       <= paused_d;
    end
  end

  assign bus.frame_tick   = frame_tick_q;
  assign bus.doodle_rst   = doodle_rst_q;
  assign bus.scroll_valid = scroll_valid_q;
  assign bus.scroll_step  = scroll_step_q;
  assign bus.score        = score_q;
  assign bus.game_state   = game_state_q;
  assign bus.paused       = paused_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: directed and randomized frames against a frame-level model.
// A second instance with a 4-cycle frame period reaches score saturation quickly.
module tb_game_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_s = 1'b1;

  game_sequencer_if gif ();
  game_sequencer_if sif ();

  game_sequencer #(.CLK(1000), .FPS(10)) dut (
    .clk_i(clk), .rst_i(rst), .bus(gif)
  );

  game_sequencer #(.CLK(4), .FPS(1)) dut_sat (
    .clk_i(clk), .rst_i(rst_s), .bus(sif)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int m_state  = 0;
  int m_score  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_tick(input int bound);
    int n = 0;
    while (gif.frame_tick !== 1'b1 && n < bound) begin
      cyc();
      n++;
    end
    chk("tick_wait", 32'(gif.frame_tick), 32'd1);
  endtask

  task automatic wait_sat_valid(input int bound);
    int n = 0;
    cyc();
    while (sif.scroll_valid !== 1'b1 && n < bound) begin
      cyc();
      n++;
    end
    chk("sat_valid_wait", 32'(sif.scroll_valid), 32'd1);
  endtask

  // One frame with doodle at row y; the model applies the game rules to predict the outcome.
  task automatic frame(input logic [9:0] y, input string tag);
    int step;
    int v;
    int yi;
    gif.doodle_y = y;
    yi = int'(y);
    wait_tick(150);
    chk({tag, "_tickstate"}, 32'(gif.game_state), m_state);
    v = 0;
    step = 0;
    if (m_state == 2) begin
      if (yi >= 768) begin
        m_state = 3;
      end else if (yi < 300) begin
        step = (300 - yi > 16) ? 16 : 300 - yi;
        v = 1;
        m_score = (m_score + step > 65535) ? 65535 : m_score + step;
      end
    end
    cyc();
    chk({tag, "_valid"}, 32'(gif.scroll_valid), v);
    if (v == 1) chk({tag, "_step"}, 32'(gif.scroll_step), step);
    chk({tag, "_score"}, 32'(gif.score), m_score);
    chk({tag, "_state"}, 32'(gif.game_state), m_state);
    chk({tag, "_drst"}, 32'(gif.doodle_rst), (m_state == 2) ? 32'd0 : 32'd1);
    cyc();
    chk({tag, "_pulse1"}, 32'(gif.scroll_valid), 32'd0);
  endtask

  initial begin
    int npulse;
    int n;
    int exp_sat;

    gif.start_btn = 1'b0;
    gif.pause_btn = 1'b0;
    gif.doodle_y  = 10'd400;
    sif.start_btn = 1'b0;
    sif.pause_btn = 1'b0;
    sif.doodle_y  = 10'd100;

    // reset and tick cadence
    cyc();
    cyc();
    rst = 1'b0;
    chk("rst_tick", 32'(gif.frame_tick), 32'd0);
    chk("rst_valid", 32'(gif.scroll_valid), 32'd0);
    chk("rst_step", 32'(gif.scroll_step), 32'd0);
    chk("rst_score", 32'(gif.score), 32'd0);
    chk("rst_state", 32'(gif.game_state), 32'd0);
    chk("rst_drst", 32'(gif.doodle_rst), 32'd1);
    chk("rst_paused", 32'(gif.paused), 32'd0);
    for (int k = 1; k <= 250; k++) begin
      cyc();
      chk("tick_period", 32'(gif.frame_tick), (k % 100 == 0) ? 32'd1 : 32'd0);
    end
    chk("idle_state", 32'(gif.game_state), 32'd0);
    chk("idle_drst", 32'(gif.doodle_rst), 32'd1);
    chk("idle_valid", 32'(gif.scroll_valid), 32'd0);

    // held start: single START, PLAY at the next tick (counter phase is 50 here)
    gif.start_btn = 1'b1;
    cyc();
    chk("start_state", 32'(gif.game_state), 32'd1);
    chk("start_drst", 32'(gif.doodle_rst), 32'd1);
    chk("start_score", 32'(gif.score), 32'd0);
    for (int k = 1; k < 500; k++) begin
      cyc();
      chk("hold_state", 32'(gif.game_state), (k < 50) ? 32'd1 : 32'd2);
      chk("hold_drst", 32'(gif.doodle_rst), (k < 50) ? 32'd1 : 32'd0);
    end
    gif.start_btn = 1'b0;
    m_state = 2;
    m_score = 0;

    // directed scroll frames
    frame(10'd290, "y290");
    frame(10'd100, "y100");
    frame(10'd400, "y400");

    // start rise in PLAY is ignored
    gif.start_btn = 1'b1;
    cyc();
    gif.start_btn = 1'b0;
    cyc();
    chk("play_start_ignored", 32'(gif.game_state), 32'd2);

    // randomized frames
    for (int i = 0; i < 16; i++) begin
      frame(10'($urandom_range(0, 700)), "rand");
    end
    frame(10'd299, "y299");
    frame(10'd300, "y300");

    // fall, then restart
    frame(10'd768, "fall");
    cyc();
    chk("over_state", 32'(gif.game_state), 32'd3);
    gif.start_btn = 1'b1;
    cyc();
    gif.start_btn = 1'b0;
    m_state = 1;
    m_score = 0;
    chk("restart_state", 32'(gif.game_state), m_state);
    chk("restart_score", 32'(gif.score), m_score);
    chk("restart_drst", 32'(gif.doodle_rst), 32'd1);
    wait_tick(150);
    cyc();
    m_state = 2;
    chk("replay_state", 32'(gif.game_state), m_state);
    frame(10'd100, "replay");

    // reset on the tick of a scrolling frame
    gif.doodle_y = 10'd100;
    wait_tick(150);
    rst = 1'b1;
    cyc();
    chk("midrst_valid", 32'(gif.scroll_valid), 32'd0);
    chk("midrst_state", 32'(gif.game_state), 32'd0);
    chk("midrst_score", 32'(gif.score), 32'd0);
    chk("midrst_drst", 32'(gif.doodle_rst), 32'd1);
    chk("midrst_tick", 32'(gif.frame_tick), 32'd0);
    rst = 1'b0;
    cyc();
    chk("midrst_valid2", 32'(gif.scroll_valid), 32'd0);
    chk("midrst_state2", 32'(gif.game_state), 32'd0);

    // score saturation on the short-period instance
    cyc();
    rst_s = 1'b0;
    sif.start_btn = 1'b1;
    cyc();
    sif.start_btn = 1'b0;
    chk("sat_start", 32'(sif.game_state), 32'd1);
    npulse = 0;
    n = 0;
    exp_sat = 0;
    while (npulse < 4095 && n < 20000) begin
      cyc();
      n++;
      if (sif.scroll_valid === 1'b1) begin
        npulse++;
        exp_sat = (exp_sat + 16 > 65535) ? 65535 : exp_sat + 16;
      end
    end
    chk("sat_pulses", npulse, 32'd4095);
    chk("sat_score_pre", 32'(sif.score), exp_sat);
    sif.doodle_y = 10'd292;
    wait_sat_valid(10);
    exp_sat = (exp_sat + 8 > 65535) ? 65535 : exp_sat + 8;
    chk("sat_step8", 32'(sif.scroll_step), 32'd8);
    chk("sat_score_fff8", 32'(sif.score), exp_sat);
    sif.doodle_y = 10'd100;
    wait_sat_valid(10);
    exp_sat = (exp_sat + 16 > 65535) ? 65535 : exp_sat + 16;
    chk("sat_score_ffff", 32'(sif.score), exp_sat);
    wait_sat_valid(10);
    exp_sat = (exp_sat + 16 > 65535) ? 65535 : exp_sat + 16;
    chk("sat_score_hold", 32'(sif.score), exp_sat);
    chk("sat_state", 32'(sif.game_state), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
